win3x3_gen: RTL
===============

# win3x3_gen

Upstream window generator for the fast median filter. It accepts a raster pixel stream and buffers the two previous image lines. For every interior pixel it presents the complete 3x3 neighbourhood as three row buses. Each row bus connects directly to the a/b/c inputs of one first-stage 3-input sorter, so the filter core receives one full window per accepted pixel.

## Interface
- DATA_W, 8: pixel width in bits
- IMG_W, 640: pixels per line (≥3)
- IMG_H, 480: lines per frame (≥3)
- clk  in  1  rising-edge clock for all state
- rst  in  1  synchronous, active-high reset
- pix_in  in  DATA_W  input pixel, raster order (left→right, top→bottom)
- in_valid  in  1  pix_in valid this cycle; always accepted (no backpressure)
- in_sof  in  1  start of frame; qualified by in_valid; marks pixel (0,0)
- row_top  out  3*DATA_W  line r-2: [3W-1:2W]=col c-2, [2W-1:W]=col c-1, [W-1:0]=col c
- row_mid  out  3*DATA_W  line r-1, same packing
- row_bot  out  3*DATA_W  line r (current), same packing
- out_valid  out  1  row buses hold a complete interior window
- out_last  out  1  with out_valid: last window of the frame

## Operation
- Counters: col 0..IMG_W-1, row 0..IMG_H-1. They advance only on in_valid.
  - col wraps to 0 at IMG_W-1 and row increments.
  - At (IMG_H-1, IMG_W-1) both wrap to 0. The next pixel starts a new frame, with or without in_sof.
- in_sof && in_valid: the pixel is placed at (0,0) regardless of current counters. This aborts any partial frame; no window is emitted for the aborted frame's pending position.
- in_sof without in_valid is ignored.
- Line buffers lb0 (line r-1) and lb1 (line r-2), each IMG_W × DATA_W, indexed by col. Register array or inferred RAM with same-cycle read-before-write.
- On accepted pixel at (r,c):
  - new column = {lb1[c], lb0[c], pix_in}
  - window shifts left by one column and the new column enters at the right
  - lb1[c] ← lb0[c]; lb0[c] ← pix_in
- out_valid ← in_valid && r≥2 && c≥2. The window is centred on (r-1, c-1). Border pixels produce no window; the output image is (IMG_W-2)×(IMG_H-2).
- out_last ← in_valid && r==IMG_H-1 && c==IMG_W-1.
- Cycles without in_valid: counters, buffers and window hold; out_valid=0, out_last=0.
- Line buffer contents are not cleared by rst or in_sof. Stale data never reaches a valid window, because rows 0–1 and cols 0–1 are gated.

## Timing
- Reset (rst=1 at a clk edge): row_top/row_mid/row_bot=0, out_valid=0, out_last=0, col=0, row=0, window registers=0.
- Latency: the window containing pixel (r,c) as its bottom-right element appears on the cycle after that pixel is accepted, with out_valid=1.
- Throughput: one window per clock for continuous in_valid.
- rst mid-frame takes priority over in_valid/in_sof in the same cycle. The first accepted pixel after reset is (0,0).
- out_valid and out_last are single-cycle pulses per accepted pixel.

## Test plan
Use IMG_W=5, IMG_H=4, pix = 16·r + c (hex 0xRC).

- Reset: hold rst 3 cycles with in_valid toggling → all outputs 0, no out_valid.
- Continuous frame: 20 pixels with in_sof on the first → exactly 6 out_valid pulses.
  - First pulse, one cycle after pixel (2,2): row_top={00,01,02}, row_mid={10,11,12}, row_bot={20,21,22}.
  - Last pulse: row_bot={32,33,34}, with out_last=1 only on that pulse.
- Gapped input: same frame with in_valid randomly low ~50% → identical sequence of 6 windows; out_valid never asserted during gaps.
- Mid-frame in_sof: assert in_sof at pixel (2,3) of frame 1, then a full frame → no window emitted for that position; the next 6 windows match the continuous case.
- Back-to-back frames, no second in_sof, pixel values +0x80 → second frame first window row_top={80,81,82}; 12 out_valid and 2 out_last in total.
- rst at pixel (3,1), then a full frame with in_sof → no stray out_valid; 6 correct windows follow.

Source files
------------

// File: rtl/win3x3_gen.sv
// win3x3_gen: 3x3 window generator for the median filter front end.
// Buffers the two previous image lines and, for every accepted pixel at
// (r,c) with r>=2 and c>=2, presents the 3x3 neighbourhood whose
// bottom-right element is that pixel.
//
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   pix_in     - raster-order input pixel
//   in_valid   - pixel valid (always accepted)
//   in_sof     - start of frame, qualified by in_valid, forces (0,0)
//   row_top    - line r-2, {col c-2, col c-1, col c}
//   row_mid    - line r-1, same packing
//   row_bot    - line r,   same packing
//   out_valid  - row buses hold a complete interior window
//   out_last   - with out_valid: last window of the frame
module win3x3_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     pix_in,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic [3*DATA_W-1:0]   row_top,
  output logic [3*DATA_W-1:0]   row_mid,
  output logic [3*DATA_W-1:0]   row_bot,
  output logic                  out_valid,
  output logic                  out_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [3*DATA_W-1:0] top_q, top_d;
  logic [3*DATA_W-1:0] mid_q, mid_d;
  logic [3*DATA_W-1:0] bot_q, bot_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;

  // Line buffers: lb0 holds line r-1, lb1 holds line r-2, indexed by column.
  logic [DATA_W-1:0]   lb0_q [IMG_W];
  logic [DATA_W-1:0]   lb1_q [IMG_W];

  logic [COL_W-1:0]    c_eff;
  logic [ROW_W-1:0]    r_eff;
  logic [DATA_W-1:0]   lb0_rd;
  logic [DATA_W-1:0]   lb1_rd;

  always_comb begin
    // A qualified start-of-frame places this pixel at (0,0) outright.
    c_eff  = (in_valid && in_sof) ? '0 : col_q;
    r_eff  = (in_valid && in_sof) ? '0 : row_q;
    lb0_rd = lb0_q[c_eff];
    lb1_rd = lb1_q[c_eff];

    col_d   = col_q;
    row_d   = row_q;
    top_d   = top_q;
    mid_d   = mid_q;
    bot_d   = bot_q;
    valid_d = 1'b0;
    last_d  = 1'b0;

    if (in_valid) begin
      // Shift the window left; the new column enters at the low slot.
      top_d   = {top_q[2*DATA_W-1:0], lb1_rd};
      mid_d   = {mid_q[2*DATA_W-1:0], lb0_rd};
      bot_d   = {bot_q[2*DATA_W-1:0], pix_in};
      valid_d = (r_eff >= ROW_W'(2)) && (c_eff >= COL_W'(2));
      last_d  = (r_eff == ROW_LAST) && (c_eff == COL_LAST);
      if (c_eff == COL_LAST) begin
        col_d = '0;
        row_d = (r_eff == ROW_LAST) ? '0 : r_eff + ROW_W'(1);
      end else begin
        col_d = c_eff + COL_W'(1);
        row_d = r_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      top_q   <= '0;
      mid_q   <= '0;
      bot_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      top_q   <= top_d;
      mid_q   <= mid_d;
      bot_q   <= bot_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Line buffers are never cleared; row/col gating keeps stale data out
  // of every valid window. Read-before-write within the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      lb1_q[c_eff] <= lb0_rd;
      lb0_q[c_eff] <= pix_in;
    end
  end

  assign row_top   = top_q;
  assign row_mid   = mid_q;
  assign row_bot   = bot_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

endmodule
